cpu_step_ctrl: RTL and testbench

Execution-enable controller between the 1 Hz clock divider and the single-cycle RISC-V core. It turns the divider's slow square wave, or a debounced push-button, into single-`clk_in`-cycle `cpu_en` pulses. The core advances one instruction per pulse and otherwise runs entirely on `clk_in`. The block also handles run/step mode selection, a sticky halt from the core, and a committed-step counter for the board display.

---
 rtl/cpu_step_pkg.sv | 14 +
 rtl/btn_debounce.sv | 45 ++++
 rtl/cpu_step_ctrl.sv | 100 ++++++++++
 tb/tb_cpu_step_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_step_pkg.sv
// Shared types and defaults for the CPU step controller.
// Imported by the debouncer and by the step controller top level.
package cpu_step_pkg;

    typedef enum logic [1:0] {
        ST_STEP,
        ST_RUN,
        ST_HALT
    } step_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int CNT_W_DEF           = 16;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-level debouncer for a bouncing button.
// The output changes only after the input has held a new level long enough.
module btn_debounce
    import cpu_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_in,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    assign cnt_nxt = cnt + 1'b1;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == dout) begin
                cnt <= '0;
            end else if (cnt_nxt == LIMIT) begin
                // the cycle that completes the count also commits the level
                dout <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt_nxt;
            end
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Turns the slow divider clock or a debounced button into one-cycle cpu_en
// pulses, with run/step selection, sticky halt and a committed-step counter.
module cpu_step_ctrl
    import cpu_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic             btn_step,
    input  logic             mode_run,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic [CNT_W-1:0] step_count,
    output logic             running,
    output logic             halted
);

    step_state_t state;
    step_state_t state_nxt;

    logic slow_s1;
    logic slow_s2;
    logic slow_prev;
    logic mode_s1;
    logic mode_run_s;
    logic btn_db;
    logic btn_prev;
    logic tick;
    logic step_req;
    logic pulse;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
        .clk_in(clk_in),
        .reset (reset),
        .din   (btn_step),
        .dout  (btn_db)
    );

    assign tick     = slow_s2 & ~slow_prev;
    assign step_req = btn_db & ~btn_prev;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            slow_s1    <= 1'b0;
            slow_s2    <= 1'b0;
            slow_prev  <= 1'b0;
            mode_s1    <= 1'b0;
            mode_run_s <= 1'b0;
            btn_prev   <= 1'b0;
        end else begin
            slow_s1    <= slow_clk;
            slow_s2    <= slow_s1;
            slow_prev  <= slow_s2;
            mode_s1    <= mode_run;
            mode_run_s <= mode_s1;
            btn_prev   <= btn_db;
        end
    end

    // halt beats mode change beats pulse; a state change drops the pulse
    always_comb begin
        state_nxt = state;
        pulse     = 1'b0;
        unique case (state)
            ST_STEP: begin
                if (halt_req)        state_nxt = ST_HALT;
                else if (mode_run_s) state_nxt = ST_RUN;
                else if (step_req)   pulse = 1'b1;
            end
            ST_RUN: begin
                if (halt_req)         state_nxt = ST_HALT;
                else if (!mode_run_s) state_nxt = ST_STEP;
                else if (tick)        pulse = 1'b1;
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_STEP;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= ST_STEP;
            cpu_en     <= 1'b0;
            step_count <= '0;
        end else begin
            state  <= state_nxt;
            cpu_en <= pulse;
            if (cpu_en) step_count <= step_count + 1'b1;
        end
    end

    assign running = (state == ST_RUN);
    assign halted  = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: mode/halt vector table plus
// a pulse-timing scoreboard for run, step, wrap, halt and mode-change cases.
module tb_cpu_step_ctrl;

    localparam int DB = 4;
    localparam int CW = 4;

    logic          clk_in = 1'b0;
    logic          reset = 1'b1;
    logic          slow_clk = 1'b0;
    logic          btn_step = 1'b0;
    logic          mode_run = 1'b0;
    logic          halt_req = 1'b0;
    logic          cpu_en;
    logic [CW-1:0] step_count;
    logic          running;
    logic          halted;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q[$];

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CW)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .slow_clk  (slow_clk),
        .btn_step  (btn_step),
        .mode_run  (mode_run),
        .halt_req  (halt_req),
        .cpu_en    (cpu_en),
        .step_count(step_count),
        .running   (running),
        .halted    (halted)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // every cpu_en pulse must match the next expected cycle in the queue
    always @(negedge clk_in) begin
        if (cpu_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_cpu_en actual_cyc=%0d required=none", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (e != cyc) begin
                    failures++;
                    $display("FAIL pulse_time actual_cyc=%0d required_cyc=%0d", cyc, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // n slow_clk rises, 6 cycles apart, each expected 3 edges after sampling
    task automatic pulses(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk_in);
            slow_clk = 1'b1;
            exp_q.push_back(cyc + 3);
            wait_neg(3);
            slow_clk = 1'b0;
            wait_neg(2);
        end
        wait_neg(4);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset = 1'b1;
        wait_neg(2);
        reset = 1'b0;
    endtask

    typedef struct {
        string name;
        bit    rst;
        bit    mode;
        bit    halt;
        int    ncyc;
        bit    exp_run;
        bit    exp_halt;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{"v_rst",       1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0};
        vecs[1] = '{"v_idle",      1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0};
        vecs[2] = '{"v_to_run",    1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0};
        vecs[3] = '{"v_to_step",   1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0};
        vecs[4] = '{"v_rerun",     1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0};
        vecs[5] = '{"v_halt",      1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1};
        vecs[6] = '{"v_stay_halt", 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b1};
        vecs[7] = '{"v_rst2",      1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        vecs[8] = '{"v_idle2",     1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0};

        // reset held while slow_clk toggles: nothing may come out
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_in);
            if (i % 10 == 0) slow_clk = ~slow_clk;
        end
        check("rst_cpu_en", 32'(cpu_en), 0);
        check("rst_count", 32'(step_count), 0);
        check("rst_running", 32'(running), 0);
        check("rst_halted", 32'(halted), 0);
        reset = 1'b0;
        // step mode ignores ticks
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_in);
            if (i % 10 == 0) slow_clk = ~slow_clk;
        end
        check("step_ignores_tick", 32'(step_count), 0);
        slow_clk = 1'b0;
        wait_neg(3);

        foreach (vecs[i]) begin
            reset    = vecs[i].rst;
            mode_run = vecs[i].mode;
            halt_req = vecs[i].halt;
            wait_neg(vecs[i].ncyc);
            check({vecs[i].name, "_running"}, 32'(running), 32'(vecs[i].exp_run));
            check({vecs[i].name, "_halted"}, 32'(halted), 32'(vecs[i].exp_halt));
            check({vecs[i].name, "_count"}, 32'(step_count), 0);
            reset    = 1'b0;
            halt_req = 1'b0;
        end

        // free-run: 200 cycles, slow_clk toggling every 10 cycles
        mode_run = 1'b1;
        wait_neg(4);
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk_in);
            if (i % 10 == 0) begin
                slow_clk = ~slow_clk;
                if (slow_clk) exp_q.push_back(cyc + 3);
            end
        end
        wait_neg(5);
        check("run_running", 32'(running), 1);
        check("run_count", 32'(step_count), 10);
        check("run_missed", 32'(exp_q.size()), 0);

        // counter wrap
        do_reset();
        wait_neg(4);
        pulses(15);
        check("wrap_15", 32'(step_count), 15);
        pulses(1);
        check("wrap_0", 32'(step_count), 0);
        pulses(1);
        check("wrap_1", 32'(step_count), 1);
        check("wrap_missed", 32'(exp_q.size()), 0);

        // bouncing button in step mode
        mode_run = 1'b0;
        do_reset();
        wait_neg(4);
        btn_step = 1'b1; wait_neg(1);
        btn_step = 1'b0; wait_neg(1);
        btn_step = 1'b1; wait_neg(1);
        btn_step = 1'b0; wait_neg(1);
        btn_step = 1'b1;
        exp_q.push_back(cyc + 7);
        wait_neg(20);
        btn_step = 1'b0;
        wait_neg(10);
        check("btn_count", 32'(step_count), 1);
        check("btn_missed", 32'(exp_q.size()), 0);

        // run mode: a button press is ignored
        mode_run = 1'b1;
        wait_neg(4);
        btn_step = 1'b1;
        wait_neg(12);
        btn_step = 1'b0;
        wait_neg(10);
        check("run_ignores_btn", 32'(step_count), 1);

        // mode falls on the same cycle as a tick: no pulse
        @(negedge clk_in);
        mode_run = 1'b0;
        slow_clk = 1'b1;
        wait_neg(5);
        slow_clk = 1'b0;
        check("modefall_running", 32'(running), 0);
        check("modefall_count", 32'(step_count), 1);

        // halt on the cycle a tick pulse would issue
        mode_run = 1'b1;
        wait_neg(4);
        @(negedge clk_in);
        slow_clk = 1'b1;
        wait_neg(2);
        halt_req = 1'b1;
        wait_neg(1);
        halt_req = 1'b0;
        check("halt_halted", 32'(halted), 1);
        check("halt_cpu_en", 32'(cpu_en), 0);
        slow_clk = 1'b0;
        wait_neg(3);
        pulses(2);
        exp_q.delete();
        btn_step = 1'b1;
        wait_neg(12);
        btn_step = 1'b0;
        wait_neg(4);
        check("halt_count", 32'(step_count), 1);
        check("halt_sticky", 32'(halted), 1);
        mode_run = 1'b0;
        @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        check("post_rst_halted", 32'(halted), 0);
        check("post_rst_running", 32'(running), 0);
        check("post_rst_count", 32'(step_count), 0);
        check("post_rst_cpu_en", 32'(cpu_en), 0);
        wait_neg(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
